// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Summary  : Shared defaults, FSM state type and round-robin search helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int ARB_N        = 8;
    localparam int ARB_IDX_W    = 3;
    localparam int ARB_HOLD_MAX = 16;
    localparam int ARB_N_MAX    = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } win_t;

    // Scans n requesters starting at ptr and wrapping modulo n; first set bit wins.
    function automatic win_t next_winner(input logic [ARB_N_MAX-1:0] req,
                                         input logic [3:0]           ptr,
                                         input int                   n);
        win_t       res;
        logic [4:0] k;
        res.found = 1'b0;
        res.idx   = 4'd0;
        for (int i = 0; i < ARB_N_MAX; i++) begin
            k = 5'(ptr) + 5'(i);
            if (int'(k) >= n) begin
                k = k - 5'(n);
            end
            if (i < n && !res.found && req[k[3:0]]) begin
                res.found = 1'b1;
                res.idx   = k[3:0];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_onehot_dec.sv
// ============================================================================
// Module   : arb_onehot_dec
// Summary  : Binary-index to one-hot decoder with enable; all zero when disabled.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_onehot_dec #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign onehot[i] = en && (idx == IDX_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
// ============================================================================
// Module   : rr_onehot_arbiter
// Summary  : Non-preemptive round-robin arbiter with index and one-hot grant.
//            Optional hold-limit revocation when ARB_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDX_W    = ARB_IDX_W,
    parameter int HOLD_MAX = ARB_HOLD_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t       state;
    arb_state_t       state_nx;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nx;
    logic [IDX_W-1:0] ptr_inc;
    logic [IDX_W-1:0] idx_nx;
    logic             valid_nx;
    logic             timeout_nx;
    logic             release_evt;
    logic             expire;
    win_t             win_ptr;
    win_t             win_inc;

    assign ptr_inc = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    assign win_ptr = next_winner(ARB_N_MAX'(req), 4'(ptr), N);
    assign win_inc = next_winner(ARB_N_MAX'(req), 4'(ptr_inc), N);

    // A revoked grant is handled exactly like a voluntary release.
    assign release_evt = (state == GRANT) && (!req[gnt_idx] || expire);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       timeout_q;

    assign expire  = (state == GRANT) && req[gnt_idx] && (hold_cnt == 8'(HOLD_MAX - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_nx;
            if (state_nx == GRANT && (state == IDLE || release_evt)) begin
                hold_cnt <= 8'd0;
            end else if (state == GRANT) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    localparam int UNUSED_HOLD_MAX = HOLD_MAX;
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        idx_nx     = gnt_idx;
        valid_nx   = gnt_valid;
        ptr_nx     = ptr;
        timeout_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_ptr.found) begin
                    state_nx = GRANT;
                    idx_nx   = IDX_W'(win_ptr.idx);
                    valid_nx = 1'b1;
                end
            end
            GRANT: begin
                if (release_evt) begin
                    ptr_nx     = ptr_inc;
                    timeout_nx = expire;
                    if (win_inc.found) begin
                        idx_nx   = IDX_W'(win_inc.idx);
                        valid_nx = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                        valid_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
        end
    end

    arb_onehot_dec #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule

`default_nettype wire

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
Round-robin arbiter that shares one decoded-select resource between N requesters. It samples a request vector and holds a registered grant for the winning requester until that requester releases. The grant is presented both as a binary index and as a one-hot vector (index decoded, bit i set for index i). It sits in front of the one-hot select path so that only one consumer drives the shared resource at a time.

Parameters:
N, 8, number of requesters; legal range 2..16.
IDX_W, 3, width of the grant index; must equal ceil(log2(N)).
HOLD_MAX, 16, maximum grant length in cycles when TIMEOUT is compiled in; legal range 2..255.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N  request vector; req[i] high = requester i wants the resource.
gnt  output  N  one-hot grant; all zero when nothing is granted.
gnt_idx  output  IDX_W  binary index of the current grantee; 0 when idle.
gnt_valid  output  1  high while a grant is held.
timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit; tied 0 unless ARB_TIMEOUT_EN is defined.

Behaviour:
- Reset, sampled at a rising edge with rst=1: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, state=IDLE, hold_cnt=0. Reset overrides everything, including a grant in progress; outputs are zero the cycle after.
- ptr (IDX_W bits) holds the highest-priority requester. Search order is ptr, ptr+1, ... N-1, 0, ... ptr-1. Indices wrap modulo N, including for non-power-of-two N.
- IDLE state:
  - If req != 0, the first set bit in search order wins.
  - Next edge: state=GRANT, gnt_idx=winner, gnt=one-hot(winner), gnt_valid=1.
  - Latency is one cycle from req sampled to grant visible.
  - If req == 0, stay in IDLE with outputs zero.
- GRANT state:
  - Held while req[gnt_idx]=1. Other requests are ignored; there is no preemption.
  - When req[gnt_idx]=0 at an edge, the grant is released and ptr becomes (gnt_idx+1) mod N.
  - In the same cycle, arbitrate the remaining req bits, searching from the new ptr.
  - If a winner exists, the new grant is visible the next cycle with no idle bubble. Otherwise go to IDLE with outputs zero.
- All outputs are registered; gnt is always exactly one-hot or zero.
- Simultaneous requests: only the first bit in search order wins; the others wait.
- A requester that deasserts before it is granted simply loses its turn; no request is latched.
- Fairness: with all N requesting continuously and each releasing after its grant, every requester is granted once per N grants.

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (8 bits) clears on each new grant and increments each GRANT cycle.
  - When hold_cnt == HOLD_MAX-1 and req[gnt_idx] is still 1, the grant is revoked as if released: ptr=(gnt_idx+1) mod N, and re-arbitration follows the GRANT rules.
  - timeout pulses 1 for exactly the cycle in which the new state or outputs appear.
  - The revoked requester may be re-granted if it is the only requester.
  - A grant therefore lasts at most HOLD_MAX cycles.
- Undefined: no counter is built, timeout is constant 0, and grants are unbounded.

Decomposition:
- Package arb_pkg holds:
  - localparams for N, IDX_W and the HOLD_MAX default;
  - the state enum {IDLE, GRANT};
  - a function next_winner(req, ptr) returning {found, idx}.
- Sub-module arb_onehot_dec: a parameterised IDX_W-to-N one-hot decoder with an enable input.
  - gnt = enable ? (1 << idx) : 0.
  - Used to drive gnt from gnt_idx and gnt_valid.

Test Plan:
- Reset then req=8'b0000_0000 for 5 cycles -> gnt=0, gnt_idx=0, gnt_valid=0 throughout.
- From reset, req=8'b0010_0100 -> one cycle later gnt=8'b0000_0100, gnt_idx=2. Hold 3 cycles, drop req[2] -> next cycle gnt=8'b0010_0000, gnt_idx=5, with no idle cycle.
- All 8 requesting, each dropping req for one cycle after its grant -> grant order 0,1,...,7,0 with no repeats within 8 grants.
- Wrap-around: ptr=7 after releasing 6, req=8'b1000_0001 -> grant 7; after release, grant 0.
- Assert rst mid-grant (gnt_idx=4) -> next cycle all outputs 0. Then req=8'b0001_0000 -> grant 4 (ptr reset to 0).
- With ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'b0000_0011 held constantly -> grant 0 for 4 cycles, then timeout=1 and grant 1 for 4 cycles, then timeout=1 and grant 0. Without the macro, grant 0 is held indefinitely and timeout stays 0.
